sparse_joiner_unit: RTL and testbench
=====================================

Name: sparse_joiner_unit

Overview:
Two-input sparse-stream joiner for the sparse accelerator tile. It merges two sorted coordinate streams, each paired with a position stream, into one output coordinate stream and two aligned output position streams. It performs intersection when joiner_op=0 and union when joiner_op=1. It sits between upstream GLB/scanner producers and downstream consumers on 17-bit valid/ready channels.

Parameters:
DATA_W, 16, payload width; each token is DATA_W+1 bits with the MSB as the control flag.
FIFO_DEPTH, 2, depth of each input and output FIFO.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
clk_en  in  1  clock enable; 0 freezes all state
flush  in  1  synchronous clear, same effect as reset
tile_en  in  1  0 forces every ready and valid low
joiner_op  in  1  0=intersect, 1=union
vector_reduce_mode  in  1  1=coordinate-only union (pos outputs idle)
coord_in_0/coord_in_1  in  17  input coordinate streams; each has _valid in 1 and _ready out 1
pos_in_0/pos_in_1  in  17  input position streams; each has _valid in 1 and _ready out 1
coord_out  out  17  output coordinate stream; _valid out 1, _ready in 1
pos_out_0/pos_out_1  out  17  output position streams; each has _valid out 1 and _ready in 1

Behaviour:
- Token encoding:
  - bit16=0: data, value in [15:0].
  - 0x1_00nn: stop token S_n, nn<0x100.
  - 0x1_0100: done.
  - 0x1_0200: empty (union filler).
  - Data coordinates are strictly increasing between stops.
- Reset/flush: on rst_n=0 or flush=1 at a clk edge with clk_en=1:
  - FIFOs empty, FSM to START.
  - All *_valid=0, all *_ready=0 the cycle after.
- Handshake: a transfer happens when valid&ready at a clk edge.
- Input side:
  - Each input channel has its own FIFO; ready = !full & tile_en.
  - Coord i and pos i are popped together only.
- Output side:
  - Each output has its own FIFO; valid = !empty & tile_en.
  - A join step fires only when all three output FIFOs (coord only in vector_reduce_mode) have space.
  - A fired step pushes to all of them in the same cycle.
- Latency: an input token accepted at edge N can appear on the outputs at edge N+2 at the earliest. Throughput is one output token per cycle.
- FSM states: START, JOIN, DRAIN0, DRAIN1, DONE. In JOIN, with heads c0/p0 and c1/p1 (processed as pairs):
  - Both data, c0==c1: emit (c0,p0,p1), pop both.
  - Both data, c0<c1: union emits (c0,p0,EMPTY) and pops 0; intersect pops 0 without emitting. The mirror case applies for c1<c0.
  - Stream 0 at stop, stream 1 data: union emits (c1,EMPTY,p1) and pops 1; intersect pops 1 without emitting. Mirror case likewise.
  - Both at stop S_n: emit S_n on all outputs, pop both. The stop levels must be equal; if they differ, S of stream 0 is emitted.
  - Both at done: emit done on all outputs, pop both, go to DONE, then START next cycle.
  - One stream at done, the other not: hold the done head and keep processing the other stream per the rules above.
- vector_reduce_mode=1:
  - Union semantics regardless of joiner_op.
  - pos inputs are still popped with their coords; pos outputs are never pushed (valid stays 0).
- clk_en=0: no state change, no handshakes complete (ready/valid held as registered).

Test Plan:
- Union, coord0=[0,2,S0,D], coord1=[1,2,S0,D], pos0=[10,11,S0,D], pos1=[20,21,S0,D]:
  - coord_out=[0,1,2,S0,D]
  - pos_out_0=[10,E,11,S0,D]
  - pos_out_1=[E,20,21,S0,D], where E=0x10200.
- Intersect on the same stimulus: coord_out=[2,S0,D], pos_out_0=[11,S0,D], pos_out_1=[21,S0,D].
- Union with an empty side, coord0=[S0,D], coord1=[3,5,S0,D]:
  - coord_out=[3,5,S0,D]
  - pos_out_0=[E,E,S0,D].
- Backpressure: randomly deassert each *_out_ready and randomize input valid. Required: output streams are identical to the no-stall run, no token is lost or duplicated, and the last token is done=0x10100.
- vector_reduce_mode=1 with the first stimulus: coord_out=[0,1,2,S0,D]; pos_out_*_valid never asserted.
- Reset/flush mid-stream: assert flush after 2 tokens. Required: all valids are 0 next cycle; a fresh stream afterwards yields the correct result with no stale tokens.

Source files
------------

// File: rtl/sparse_joiner_if.sv
// Valid/ready channel bundle for the sparse joiner: two coord/pos input pairs,
// one coord output and two aligned pos outputs.
interface sparse_joiner_if #(
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned TOK_W = DATA_W + 1;

   logic [TOK_W-1:0] coord_in_0, coord_in_1, pos_in_0, pos_in_1;
   logic             coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid;
   logic             coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;

   logic [TOK_W-1:0] coord_out, pos_out_0, pos_out_1;
   logic             coord_out_valid, pos_out_0_valid, pos_out_1_valid;
   logic             coord_out_ready, pos_out_0_ready, pos_out_1_ready;

   modport slave (
      input  coord_in_0, coord_in_1, pos_in_0, pos_in_1,
      input  coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid,
      output coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready,
      output coord_out, pos_out_0, pos_out_1,
      output coord_out_valid, pos_out_0_valid, pos_out_1_valid,
      input  coord_out_ready, pos_out_0_ready, pos_out_1_ready
   );

   modport master (
      output coord_in_0, coord_in_1, pos_in_0, pos_in_1,
      output coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid,
      input  coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready,
      input  coord_out, pos_out_0, pos_out_1,
      input  coord_out_valid, pos_out_0_valid, pos_out_1_valid,
      output coord_out_ready, pos_out_0_ready, pos_out_1_ready
   );
endinterface

// File: rtl/sparse_joiner_unit.sv
// Two-input sparse-stream joiner: intersects or unions two sorted coordinate
// streams and emits one coord stream plus two aligned position streams.
module sparse_joiner_fifo #(
   parameter int unsigned W     = 17,
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (en && do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         if (!rst_n || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({do_push, do_pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end
endmodule

module sparse_joiner_unit #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clk_en,
   input  logic            flush,
   input  logic            tile_en,
   input  logic            joiner_op,
   input  logic            vector_reduce_mode,
   sparse_joiner_if.slave  bus
);
   localparam int unsigned TOK_W = DATA_W + 1;
   localparam logic [TOK_W-1:0] TOK_DONE  = {1'b1, DATA_W'(32'h0100)};
   localparam logic [TOK_W-1:0] TOK_EMPTY = {1'b1, DATA_W'(32'h0200)};

   typedef enum logic [2:0] {ST_START, ST_JOIN, ST_DRAIN0, ST_DRAIN1, ST_DONE} state_t;

   state_t state_q, state_d;
   logic   active;

   // Channel order: 0=coord0, 1=pos0, 2=coord1, 3=pos1
   logic [TOK_W-1:0] in_data [4];
   logic [TOK_W-1:0] in_head [4];
   logic [3:0]       in_valid, in_ready, in_full, in_empty, in_pop;

   // Channel order: 0=coord, 1=pos0, 2=pos1
   logic [TOK_W-1:0] out_data [3];
   logic [TOK_W-1:0] out_head [3];
   logic [2:0]       out_push, out_pop, out_full, out_empty, out_valid, out_ready;

   logic             pop0, pop1, emit;
   logic [TOK_W-1:0] oc, op0, op1;
   logic             d0, d1, done0, done1, heads_ok, space, run, union_m;

   // Ready is held low for the first cycle after reset/flush
   always_ff @(posedge clk) begin
      if (clk_en) active <= rst_n && !flush;
   end

   assign in_data  = '{bus.coord_in_0, bus.pos_in_0, bus.coord_in_1, bus.pos_in_1};
   assign in_valid = {bus.pos_in_1_valid, bus.coord_in_1_valid, bus.pos_in_0_valid, bus.coord_in_0_valid};
   assign in_ready = {4{active & tile_en}} & ~in_full;
   assign in_pop   = {pop1, pop1, pop0, pop0};

   assign bus.coord_in_0_ready = in_ready[0];
   assign bus.pos_in_0_ready   = in_ready[1];
   assign bus.coord_in_1_ready = in_ready[2];
   assign bus.pos_in_1_ready   = in_ready[3];

   for (genvar i = 0; i < 4; i++) begin : g_in_fifo
      sparse_joiner_fifo #(.W(TOK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk(clk), .rst_n(rst_n), .en(clk_en), .clr(flush),
         .push(in_valid[i] & in_ready[i]), .din(in_data[i]),
         .pop(in_pop[i]), .dout(in_head[i]), .full(in_full[i]), .empty(in_empty[i])
      );
   end

   assign out_data  = '{oc, op0, op1};
   assign out_push  = {emit & ~vector_reduce_mode, emit & ~vector_reduce_mode, emit};
   assign out_valid = {3{tile_en}} & ~out_empty;
   assign out_ready = {bus.pos_out_1_ready, bus.pos_out_0_ready, bus.coord_out_ready};
   assign out_pop   = out_valid & out_ready;

   for (genvar i = 0; i < 3; i++) begin : g_out_fifo
      sparse_joiner_fifo #(.W(TOK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk(clk), .rst_n(rst_n), .en(clk_en), .clr(flush),
         .push(out_push[i]), .din(out_data[i]),
         .pop(out_pop[i]), .dout(out_head[i]), .full(out_full[i]), .empty(out_empty[i])
      );
   end

   assign bus.coord_out       = out_head[0];
   assign bus.pos_out_0       = out_head[1];
   assign bus.pos_out_1       = out_head[2];
   assign bus.coord_out_valid = out_valid[0];
   assign bus.pos_out_0_valid = out_valid[1];
   assign bus.pos_out_1_valid = out_valid[2];

   // Head decode; a join step needs all four heads and room in every active output
   assign d0       = !in_head[0][DATA_W];
   assign d1       = !in_head[2][DATA_W];
   assign done0    = (in_head[0] == TOK_DONE);
   assign done1    = (in_head[2] == TOK_DONE);
   assign heads_ok = ~|in_empty;
   assign space    = !out_full[0] && (vector_reduce_mode || (!out_full[1] && !out_full[2]));
   assign union_m  = joiner_op | vector_reduce_mode;
   assign run      = (state_q == ST_JOIN || state_q == ST_DRAIN0 || state_q == ST_DRAIN1)
                     && heads_ok && space;

   always_ff @(posedge clk) begin
      if (clk_en) begin
         if (!rst_n || flush) state_q <= ST_START;
         else                 state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START:  state_d = ST_JOIN;
         ST_JOIN: begin
            if (run && done0 && done1)  state_d = ST_DONE;
            else if (run && done1)      state_d = ST_DRAIN0;
            else if (run && done0)      state_d = ST_DRAIN1;
         end
         ST_DRAIN0, ST_DRAIN1: begin
            if (run && done0 && done1)  state_d = ST_DONE;
         end
         ST_DONE:   state_d = ST_START;
         default:   state_d = ST_START;
      endcase
   end

   // Join step: choose which heads to pop and what triple to emit
   always_comb begin
      pop0 = 1'b0;
      pop1 = 1'b0;
      emit = 1'b0;
      oc   = in_head[0];
      op0  = in_head[1];
      op1  = in_head[3];
      if (run) begin
         if (d0 && d1) begin
            if (in_head[0][DATA_W-1:0] == in_head[2][DATA_W-1:0]) begin
               pop0 = 1'b1;
               pop1 = 1'b1;
               emit = 1'b1;
            end else if (in_head[0][DATA_W-1:0] < in_head[2][DATA_W-1:0]) begin
               pop0 = 1'b1;
               emit = union_m;
               op1  = TOK_EMPTY;
            end else begin
               pop1 = 1'b1;
               emit = union_m;
               oc   = in_head[2];
               op0  = TOK_EMPTY;
            end
         end else if (d1) begin
            pop1 = 1'b1;
            emit = union_m;
            oc   = in_head[2];
            op0  = TOK_EMPTY;
         end else if (d0) begin
            pop0 = 1'b1;
            emit = union_m;
            op1  = TOK_EMPTY;
         end else if (done0 && done1) begin
            pop0 = 1'b1;
            pop1 = 1'b1;
            emit = 1'b1;
            oc   = TOK_DONE;
            op0  = TOK_DONE;
            op1  = TOK_DONE;
         end else if (done0) begin
            // Stream 0 finished early: forward stream 1's stop alone
            pop1 = 1'b1;
            emit = 1'b1;
            oc   = in_head[2];
            op0  = in_head[2];
            op1  = in_head[2];
         end else if (done1) begin
            pop0 = 1'b1;
            emit = 1'b1;
            op0  = in_head[0];
            op1  = in_head[0];
         end else begin
            // Both at stop: stream 0's level wins on a mismatch
            pop0 = 1'b1;
            pop1 = 1'b1;
            emit = 1'b1;
            op0  = in_head[0];
            op1  = in_head[0];
         end
      end
   end
endmodule

// File: tb/tb_sparse_joiner_unit.sv
// Directed bench for sparse_joiner_unit: union, intersect, empty side,
// backpressure, vector-reduce mode and mid-stream flush.
module tb_sparse_joiner_unit;
   typedef logic [16:0] tok_t;
   localparam tok_t S0 = 17'h10000;
   localparam tok_t D  = 17'h10100;
   localparam tok_t E  = 17'h10200;

   logic clk = 1'b0;
   logic rst_n, clk_en, flush, tile_en, joiner_op, vector_reduce_mode;

   sparse_joiner_if #(.DATA_W(16)) bus ();

   sparse_joiner_unit #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
      .joiner_op(joiner_op), .vector_reduce_mode(vector_reduce_mode), .bus(bus)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   tok_t q_c0[$], q_p0[$], q_c1[$], q_p1[$];
   tok_t o_c[$], o_p0[$], o_p1[$];
   tok_t e_c[$], e_p0[$], e_p1[$];
   bit   pos_seen;

   task automatic idle_inputs();
      bus.coord_in_0_valid = 0; bus.pos_in_0_valid = 0;
      bus.coord_in_1_valid = 0; bus.pos_in_1_valid = 0;
      bus.coord_in_0 = '0; bus.pos_in_0 = '0; bus.coord_in_1 = '0; bus.pos_in_1 = '0;
      bus.coord_out_ready = 1; bus.pos_out_0_ready = 1; bus.pos_out_1_ready = 1;
   endtask

   task automatic load_first();
      q_c0 = '{17'd0, 17'd2, S0, D};   q_p0 = '{17'd10, 17'd11, S0, D};
      q_c1 = '{17'd1, 17'd2, S0, D};   q_p1 = '{17'd20, 17'd21, S0, D};
   endtask

   task automatic load_empty_side();
      q_c0 = '{S0, D};                 q_p0 = '{S0, D};
      q_c1 = '{17'd3, 17'd5, S0, D};   q_p1 = '{17'd30, 17'd31, S0, D};
   endtask

   // Streams the loaded queues through the DUT and captures the outputs
   task automatic run_case(input bit stall, input int flush_after, output bit ok);
      int  i0 = 0, i1 = 0, i2 = 0, i3 = 0;
      bit  a0, a1, a2, a3;
      o_c.delete(); o_p0.delete(); o_p1.delete();
      pos_seen = 0;
      ok = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (flush_after >= 0 && i0 >= flush_after) begin
            idle_inputs();
            flush = 1;
            @(posedge clk);
            #1;
            ok = 1;
            return;
         end
         bus.coord_in_0_valid = (i0 < q_c0.size()) && (!stall || $urandom_range(0, 3) != 0);
         bus.pos_in_0_valid   = (i1 < q_p0.size()) && (!stall || $urandom_range(0, 3) != 0);
         bus.coord_in_1_valid = (i2 < q_c1.size()) && (!stall || $urandom_range(0, 3) != 0);
         bus.pos_in_1_valid   = (i3 < q_p1.size()) && (!stall || $urandom_range(0, 3) != 0);
         bus.coord_in_0 = (i0 < q_c0.size()) ? q_c0[i0] : '0;
         bus.pos_in_0   = (i1 < q_p0.size()) ? q_p0[i1] : '0;
         bus.coord_in_1 = (i2 < q_c1.size()) ? q_c1[i2] : '0;
         bus.pos_in_1   = (i3 < q_p1.size()) ? q_p1[i3] : '0;
         bus.coord_out_ready = !stall || $urandom_range(0, 2) != 0;
         bus.pos_out_0_ready = !stall || $urandom_range(0, 2) != 0;
         bus.pos_out_1_ready = !stall || $urandom_range(0, 2) != 0;
         #1;
         a0 = bus.coord_in_0_valid && bus.coord_in_0_ready;
         a1 = bus.pos_in_0_valid && bus.pos_in_0_ready;
         a2 = bus.coord_in_1_valid && bus.coord_in_1_ready;
         a3 = bus.pos_in_1_valid && bus.pos_in_1_ready;
         if (bus.coord_out_valid && bus.coord_out_ready) o_c.push_back(bus.coord_out);
         if (bus.pos_out_0_valid && bus.pos_out_0_ready) o_p0.push_back(bus.pos_out_0);
         if (bus.pos_out_1_valid && bus.pos_out_1_ready) o_p1.push_back(bus.pos_out_1);
         if (bus.pos_out_0_valid || bus.pos_out_1_valid) pos_seen = 1;
         @(posedge clk);
         i0 += int'(a0); i1 += int'(a1); i2 += int'(a2); i3 += int'(a3);
         if (o_c.size() > 0 && o_c[$] == D &&
             (vector_reduce_mode || (o_p0.size() > 0 && o_p0[$] == D && o_p1.size() > 0 && o_p1[$] == D))) begin
            ok = 1;
            break;
         end
      end
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0; clk_en = 1; flush = 0; tile_en = 1; joiner_op = 1; vector_reduce_mode = 0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.coord_in_0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", bus.coord_in_0_ready); end
      tests++; if (bus.coord_out_valid !== 1'b0) begin fails++; $display("FAIL reset_coord_valid got %b exp 0", bus.coord_out_valid); end
      tests++; if ({bus.pos_out_0_valid, bus.pos_out_1_valid} !== 2'b00) begin fails++; $display("FAIL reset_pos_valid got %b exp 00", {bus.pos_out_0_valid, bus.pos_out_1_valid}); end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      tests++; if ({bus.coord_in_0_ready, bus.pos_in_1_ready} !== 2'b11) begin fails++; $display("FAIL ready_after_reset got %b exp 11", {bus.coord_in_0_ready, bus.pos_in_1_ready}); end
      tile_en = 0;
      #1;
      tests++; if (bus.coord_in_1_ready !== 1'b0) begin fails++; $display("FAIL tile_en_gate got %b exp 0", bus.coord_in_1_ready); end
      tile_en = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_union();
      bit ok;
      joiner_op = 1; vector_reduce_mode = 0; load_first();
      e_c = '{17'd0, 17'd1, 17'd2, S0, D}; e_p0 = '{17'd10, E, 17'd11, S0, D}; e_p1 = '{E, 17'd20, 17'd21, S0, D};
      run_case(0, -1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL union_timeout got %0d exp 1", ok); end
      tests++; if (o_c.size() != e_c.size()) begin fails++; $display("FAIL union_len got %0d exp %0d", o_c.size(), e_c.size()); end
      foreach (e_c[i]) begin
         tests++;
         if (i >= o_c.size() || o_c[i] !== e_c[i] || i >= o_p0.size() || o_p0[i] !== e_p0[i] || i >= o_p1.size() || o_p1[i] !== e_p1[i]) begin
            fails++; $display("FAIL union[%0d] got %h/%h/%h exp %h/%h/%h", i, o_c[i], o_p0[i], o_p1[i], e_c[i], e_p0[i], e_p1[i]);
         end
      end
   endtask

   task automatic test_intersect();
      bit ok;
      joiner_op = 0; vector_reduce_mode = 0; load_first();
      e_c = '{17'd2, S0, D}; e_p0 = '{17'd11, S0, D}; e_p1 = '{17'd21, S0, D};
      run_case(0, -1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL intersect_timeout got %0d exp 1", ok); end
      tests++; if (o_c.size() != e_c.size() || o_p0.size() != e_p0.size()) begin fails++; $display("FAIL intersect_len got %0d/%0d exp %0d", o_c.size(), o_p0.size(), e_c.size()); end
      foreach (e_c[i]) begin
         tests++;
         if (i >= o_c.size() || o_c[i] !== e_c[i] || i >= o_p0.size() || o_p0[i] !== e_p0[i] || i >= o_p1.size() || o_p1[i] !== e_p1[i]) begin
            fails++; $display("FAIL intersect[%0d] got %h/%h/%h exp %h/%h/%h", i, o_c[i], o_p0[i], o_p1[i], e_c[i], e_p0[i], e_p1[i]);
         end
      end
   endtask

   task automatic test_empty_side();
      bit ok;
      joiner_op = 1; vector_reduce_mode = 0; load_empty_side();
      e_c = '{17'd3, 17'd5, S0, D}; e_p0 = '{E, E, S0, D}; e_p1 = '{17'd30, 17'd31, S0, D};
      run_case(0, -1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL empty_side_timeout got %0d exp 1", ok); end
      tests++; if (o_c.size() != e_c.size()) begin fails++; $display("FAIL empty_side_len got %0d exp %0d", o_c.size(), e_c.size()); end
      foreach (e_c[i]) begin
         tests++;
         if (i >= o_c.size() || o_c[i] !== e_c[i] || i >= o_p0.size() || o_p0[i] !== e_p0[i] || i >= o_p1.size() || o_p1[i] !== e_p1[i]) begin
            fails++; $display("FAIL empty_side[%0d] got %h/%h/%h exp %h/%h/%h", i, o_c[i], o_p0[i], o_p1[i], e_c[i], e_p0[i], e_p1[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      joiner_op = 1; vector_reduce_mode = 0;
      e_c = '{17'd0, 17'd1, 17'd2, S0, D}; e_p0 = '{17'd10, E, 17'd11, S0, D}; e_p1 = '{E, 17'd20, 17'd21, S0, D};
      for (int rep = 0; rep < 3; rep++) begin
         load_first();
         run_case(1, -1, ok);
         tests++; if (!ok) begin fails++; $display("FAIL stall_timeout rep %0d got %0d exp 1", rep, ok); end
         tests++; if (o_c.size() != 5 || o_p0.size() != 5 || o_p1.size() != 5) begin fails++; $display("FAIL stall_len rep %0d got %0d/%0d/%0d exp 5", rep, o_c.size(), o_p0.size(), o_p1.size()); end
         tests++; if (o_c.size() == 0 || o_c[$] !== D) begin fails++; $display("FAIL stall_last rep %0d got %h exp %h", rep, (o_c.size() > 0) ? o_c[$] : 17'h0, D); end
         foreach (e_c[i]) begin
            tests++;
            if (i >= o_c.size() || o_c[i] !== e_c[i] || i >= o_p0.size() || o_p0[i] !== e_p0[i] || i >= o_p1.size() || o_p1[i] !== e_p1[i]) begin
               fails++; $display("FAIL stall[%0d] rep %0d got %h/%h/%h exp %h/%h/%h", i, rep, o_c[i], o_p0[i], o_p1[i], e_c[i], e_p0[i], e_p1[i]);
            end
         end
      end
   endtask

   task automatic test_vector_reduce();
      bit ok;
      joiner_op = 0; vector_reduce_mode = 1; load_first();
      e_c = '{17'd0, 17'd1, 17'd2, S0, D};
      run_case(0, -1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL vrm_timeout got %0d exp 1", ok); end
      tests++; if (pos_seen !== 1'b0 || o_p0.size() != 0 || o_p1.size() != 0) begin fails++; $display("FAIL vrm_pos_valid got %b exp 0", pos_seen); end
      tests++; if (o_c.size() != e_c.size()) begin fails++; $display("FAIL vrm_len got %0d exp %0d", o_c.size(), e_c.size()); end
      foreach (e_c[i]) begin
         tests++;
         if (i >= o_c.size() || o_c[i] !== e_c[i]) begin fails++; $display("FAIL vrm[%0d] got %h exp %h", i, o_c[i], e_c[i]); end
      end
      vector_reduce_mode = 0;
   endtask

   task automatic test_flush();
      bit ok;
      joiner_op = 1; vector_reduce_mode = 0; load_first();
      run_case(0, 2, ok);
      tests++; if (!ok) begin fails++; $display("FAIL flush_reach got %0d exp 1", ok); end
      tests++; if ({bus.coord_out_valid, bus.pos_out_0_valid, bus.pos_out_1_valid} !== 3'b000) begin
         fails++; $display("FAIL flush_valid got %b exp 000", {bus.coord_out_valid, bus.pos_out_0_valid, bus.pos_out_1_valid});
      end
      tests++; if (bus.coord_in_0_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b exp 0", bus.coord_in_0_ready); end
      @(negedge clk);
      flush = 0;
      repeat (2) @(negedge clk);
      load_empty_side();
      e_c = '{17'd3, 17'd5, S0, D}; e_p0 = '{E, E, S0, D}; e_p1 = '{17'd30, 17'd31, S0, D};
      run_case(0, -1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL post_flush_timeout got %0d exp 1", ok); end
      tests++; if (o_c.size() != e_c.size()) begin fails++; $display("FAIL post_flush_len got %0d exp %0d", o_c.size(), e_c.size()); end
      foreach (e_c[i]) begin
         tests++;
         if (i >= o_c.size() || o_c[i] !== e_c[i] || i >= o_p0.size() || o_p0[i] !== e_p0[i] || i >= o_p1.size() || o_p1[i] !== e_p1[i]) begin
            fails++; $display("FAIL post_flush[%0d] got %h/%h/%h exp %h/%h/%h", i, o_c[i], o_p0[i], o_p1[i], e_c[i], e_p0[i], e_p1[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_union();
      test_intersect();
      test_empty_side();
      test_back_to_back();
      test_vector_reduce();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
